// File: rtl/apb_master_arb_pkg.sv
// apb_ctrl_pkg: shared types, sizes and address-decode helpers for the APB master arbiter.
package apb_ctrl_pkg;

   localparam int NUM_REQ        = 2;
   localparam int NUM_SLV        = 4;
   localparam int ADDR_W         = 32;
   localparam int DATA_W         = 32;
   localparam int DEC_HI         = 31;
   localparam int DEC_LO         = 28;
   localparam int DEC_W          = DEC_HI - DEC_LO + 1;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int TO_W           = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   // Any decode field value at or above the slave count has no slave behind it.
   function automatic logic decode_err(input logic [DEC_W-1:0] f);
      return f >= DEC_W'(NUM_SLV);
   endfunction

   function automatic logic [NUM_SLV-1:0] decode_sel(input logic [DEC_W-1:0] f);
      logic [NUM_SLV-1:0] sel;
      sel = '0;
      if (!decode_err(f))
         sel[f[$clog2(NUM_SLV)-1:0]] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if: requester-side handshake plus APB bus signals for apb_master_arb.
interface apb_master_arb_if;
   import apb_ctrl_pkg::*;

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_write;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [DATA_W-1:0]              rsp_rdata;
   logic                           rsp_err;

   logic [NUM_SLV-1:0]             PSEL;
   logic                           PENABLE;
   logic                           PWRITE;
   logic [ADDR_W-1:0]              PADDR;
   logic [DATA_W-1:0]              PWDATA;
   logic [DATA_W-1:0]              PRDATA;
   logic                           PREADY;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

endinterface

// File: rtl/apb_master_arb_rr.sv
// apb_rr_arb: two-requester round-robin arbiter; the pointer moves only when a grant is accepted.
module apb_rr_arb (
   input  logic       CLK,
   input  logic       PRESET,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   logic prio_p1;  // 1: requester 1 wins a tie

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || !prio_p1))
         gnt = 2'b01;
      else if (req[1])
         gnt = 2'b10;
   end

   always_ff @(posedge CLK) begin
      if (PRESET)
         prio_p1 <= 1'b0;
      else if (accept && (|gnt))
         prio_p1 <= gnt[0];
   end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester APB master with round-robin grant and PADDR[31:28] decode.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES consecutive PREADY=0 cycles.
module apb_master_arb
   import apb_ctrl_pkg::*;
(
   input  logic             CLK,
   input  logic             PRESET,
   apb_master_arb_if.master bus
);

   apb_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] gnt;
   logic               accept, sel_idx, dec_err, xfer_done, xfer_abort;
   logic               owner, cap_write;
   logic [ADDR_W-1:0]  cap_addr;
   logic [DATA_W-1:0]  cap_wdata, rsp_rdata_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic               rsp_err_q;

   assign accept    = (state == IDLE) && (|bus.req_valid);
   assign sel_idx   = gnt[1];
   assign dec_err   = decode_err(bus.req_addr[sel_idx][DEC_HI:DEC_LO]);
   assign xfer_done = (state == ACCESS) && bus.PREADY;

   apb_rr_arb u_arb (
      .CLK    (CLK),
      .PRESET (PRESET),
      .req    (bus.req_valid),
      .accept (accept),
      .gnt    (gnt)
   );

`ifdef APB_TIMEOUT_EN
   logic [TO_W-1:0] wait_cnt;

   always_ff @(posedge CLK) begin
      if (PRESET || (state != ACCESS))
         wait_cnt <= '0;
      else if (!bus.PREADY)
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign xfer_abort = (state == ACCESS) && !bus.PREADY &&
                       (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign xfer_abort = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (PRESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !dec_err) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (xfer_done || xfer_abort) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      bus.PSEL      = '0;
      bus.PENABLE   = 1'b0;
      bus.PWRITE    = 1'b0;
      bus.PADDR     = '0;
      bus.PWDATA    = '0;
      case (state)
         IDLE: bus.req_ready = gnt;
         SETUP, ACCESS: begin
            bus.PSEL    = decode_sel(cap_addr[DEC_HI:DEC_LO]);
            bus.PENABLE = (state == ACCESS);
            bus.PWRITE  = cap_write;
            bus.PADDR   = cap_addr;
            bus.PWDATA  = cap_write ? cap_wdata : '0;
         end
         default: ;
      endcase
   end

   // Request fields are latched at accept and held for the whole transfer.
   always_ff @(posedge CLK) begin
      if (accept) begin
         owner     <= sel_idx;
         cap_write <= bus.req_write[sel_idx];
         cap_addr  <= bus.req_addr[sel_idx];
         cap_wdata <= bus.req_wdata[sel_idx];
      end
   end

   // Responses are single-cycle pulses issued the cycle after completion, abort or decode error.
   always_ff @(posedge CLK) begin
      if (PRESET) begin
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         if (accept && dec_err) begin
            rsp_valid_q <= gnt;
            rsp_err_q   <= 1'b1;
         end else if (xfer_done) begin
            rsp_valid_q[owner] <= 1'b1;
            rsp_rdata_q        <= cap_write ? '0 : bus.PRDATA;
         end else if (xfer_abort) begin
            rsp_valid_q[owner] <= 1'b1;
            rsp_err_q          <= 1'b1;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed self-checking bench for apb_master_arb (timeout case follows APB_TIMEOUT_EN).
module tb_apb_master_arb;

   logic CLK = 1'b0;
   logic PRESET;
   int   total = 0;
   int   bad   = 0;

   apb_master_arb_if bus ();

   apb_master_arb dut (
      .CLK    (CLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      step();
      step();
      PRESET = 1'b0;
      #1;
      total++; if (bus.PSEL !== 4'b0)      begin bad++; $display("FAIL rst_psel got %b want 0000", bus.PSEL); end
      total++; if (bus.PENABLE !== 1'b0)   begin bad++; $display("FAIL rst_penable got %b want 0", bus.PENABLE); end
      total++; if (bus.req_ready !== 2'b0) begin bad++; $display("FAIL rst_req_ready got %b want 00", bus.req_ready); end
      total++; if (bus.rsp_valid !== 2'b0) begin bad++; $display("FAIL rst_rsp_valid got %b want 00", bus.rsp_valid); end
      total++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0)
         begin bad++; $display("FAIL rst_rsp got rdata=%h err=%b want 0/0", bus.rsp_rdata, bus.rsp_err); end
      total++; if (bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 || bus.PWRITE !== 1'b0)
         begin bad++; $display("FAIL rst_apb got addr=%h wdata=%h wr=%b want 0", bus.PADDR, bus.PWDATA, bus.PWRITE); end
   endtask

   task automatic test_single_write();
      bus.req_valid    = 2'b01;
      bus.req_write    = 2'b01;
      bus.req_addr[0]  = 32'h1000_0040;
      bus.req_wdata[0] = 32'hDEAD_BEEF;
      bus.PREADY       = 1'b1;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL wr_accept got %b want 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      #1;
      total++; if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b0)
         begin bad++; $display("FAIL wr_setup got psel=%b en=%b want 0010/0", bus.PSEL, bus.PENABLE); end
      total++; if (bus.PADDR !== 32'h1000_0040 || bus.PWDATA !== 32'hDEAD_BEEF || bus.PWRITE !== 1'b1)
         begin bad++; $display("FAIL wr_setup_fields got %h %h %b want 10000040 deadbeef 1", bus.PADDR, bus.PWDATA, bus.PWRITE); end
      step();
      total++; if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b1 || bus.PWDATA !== 32'hDEAD_BEEF)
         begin bad++; $display("FAIL wr_access got psel=%b en=%b wdata=%h want 0010/1/deadbeef", bus.PSEL, bus.PENABLE, bus.PWDATA); end
      total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_early_rsp got %b want 00", bus.rsp_valid); end
      step();
      total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0)
         begin bad++; $display("FAIL wr_rsp got v=%b err=%b rd=%h want 01/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      total++; if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0)
         begin bad++; $display("FAIL wr_idle_apb got psel=%b en=%b addr=%h wd=%h want 0", bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA); end
      step();
      total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL wr_rsp_pulse got %b want 00", bus.rsp_valid); end
   endtask

   task automatic test_read_wait();
      int en_cycles;
      bus.req_valid    = 2'b10;
      bus.req_write    = 2'b00;
      bus.req_addr[1]  = 32'h3000_0000;
      bus.req_wdata[1] = 32'hFFFF_FFFF;
      bus.PREADY       = 1'b0;
      bus.PRDATA       = 32'h0;
      #1;
      total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL rd_accept got %b want 10", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      #1;
      total++; if (bus.PSEL !== 4'b1000 || bus.PWRITE !== 1'b0 || bus.PWDATA !== 32'h0)
         begin bad++; $display("FAIL rd_setup got psel=%b wr=%b wd=%h want 1000/0/0", bus.PSEL, bus.PWRITE, bus.PWDATA); end
      en_cycles = 0;
      step();
      if (bus.PENABLE) en_cycles++;
      step();
      if (bus.PENABLE) en_cycles++;
      total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rd_wait_rsp got %b want 00", bus.rsp_valid); end
      step();
      if (bus.PENABLE) en_cycles++;
      total++; if (bus.PSEL !== 4'b1000 || bus.PADDR !== 32'h3000_0000)
         begin bad++; $display("FAIL rd_hold got psel=%b addr=%h want 1000/30000000", bus.PSEL, bus.PADDR); end
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h1234_5678;
      step();
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h0;
      total++; if (en_cycles !== 3) begin bad++; $display("FAIL rd_penable_cycles got %0d want 3", en_cycles); end
      total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_err !== 1'b0)
         begin bad++; $display("FAIL rd_rsp got v=%b rd=%h err=%b want 10/12345678/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
      step();
   endtask

   task automatic test_back_to_back();
      bus.req_valid    = 2'b01;
      bus.req_write    = 2'b01;
      bus.req_addr[0]  = 32'h0000_0008;
      bus.req_wdata[0] = 32'h0000_0011;
      bus.PREADY       = 1'b1;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL b2b_accept1 got %b want 01", bus.req_ready); end
      step();
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL b2b_ready_setup got %b want 00", bus.req_ready); end
      step();
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL b2b_ready_access got %b want 00", bus.req_ready); end
      step();
      total++; if (bus.rsp_valid !== 2'b01 || bus.req_ready !== 2'b01)
         begin bad++; $display("FAIL b2b_rsp_accept got v=%b rdy=%b want 01/01", bus.rsp_valid, bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      #1;
      total++; if (bus.PSEL !== 4'b0001 || bus.PENABLE !== 1'b0)
         begin bad++; $display("FAIL b2b_setup2 got psel=%b en=%b want 0001/0", bus.PSEL, bus.PENABLE); end
      step();
      step();
      total++; if (bus.rsp_valid !== 2'b01) begin bad++; $display("FAIL b2b_rsp2 got %b want 01", bus.rsp_valid); end
      step();
   endtask

   task automatic test_contention();
      logic [1:0] seq [4];
      int         at  [4];
      int         gcnt;
      PRESET = 1'b1;
      step();
      PRESET = 1'b0;
      bus.req_valid    = 2'b11;
      bus.req_write    = 2'b11;
      bus.req_addr[0]  = 32'h0000_0100;
      bus.req_addr[1]  = 32'h2000_0200;
      bus.req_wdata[0] = 32'hAAAA_0000;
      bus.req_wdata[1] = 32'hBBBB_0000;
      bus.PREADY       = 1'b1;
      #1;
      gcnt = 0;
      for (int c = 0; c < 12; c++) begin
         total++; if (bus.req_ready === 2'b11) begin bad++; $display("FAIL cont_double_ready cycle %0d got 11 want one-hot", c); end
         if (bus.req_ready !== 2'b00 && gcnt < 4) begin
            seq[gcnt] = bus.req_ready;
            at[gcnt]  = c;
            gcnt++;
         end
         step();
      end
      bus.req_valid = 2'b00;
      total++; if (gcnt !== 4) begin bad++; $display("FAIL cont_grant_count got %0d want 4", gcnt); end
      for (int g = 0; g < 4 && g < gcnt; g++) begin
         total++; if (seq[g] !== ((g % 2 == 0) ? 2'b01 : 2'b10) || at[g] !== 3 * g)
            begin bad++; $display("FAIL cont_grant%0d got %b@%0d want %b@%0d", g, seq[g], at[g], (g % 2 == 0) ? 2'b01 : 2'b10, 3 * g); end
      end
      step();
      step();
   endtask

   task automatic test_decode_err();
      bus.req_valid   = 2'b01;
      bus.req_write   = 2'b00;
      bus.req_addr[0] = 32'h7000_0000;
      #1;
      total++; if (bus.req_ready !== 2'b01 || bus.PSEL !== 4'b0)
         begin bad++; $display("FAIL dec_accept got rdy=%b psel=%b want 01/0000", bus.req_ready, bus.PSEL); end
      step();
      bus.req_valid   = 2'b10;
      bus.req_addr[1] = 32'h4000_0000;
      #1;
      total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0)
         begin bad++; $display("FAIL dec_rsp0 got v=%b err=%b rd=%h want 01/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      total++; if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.req_ready !== 2'b10)
         begin bad++; $display("FAIL dec_idle got psel=%b en=%b rdy=%b want 0000/0/10", bus.PSEL, bus.PENABLE, bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      #1;
      total++; if (bus.rsp_valid !== 2'b10 || bus.rsp_err !== 1'b1 || bus.PSEL !== 4'b0)
         begin bad++; $display("FAIL dec_rsp1 got v=%b err=%b psel=%b want 10/1/0000", bus.rsp_valid, bus.rsp_err, bus.PSEL); end
      step();
      total++; if (bus.rsp_valid !== 2'b00 || bus.PSEL !== 4'b0)
         begin bad++; $display("FAIL dec_quiet got v=%b psel=%b want 00/0000", bus.rsp_valid, bus.PSEL); end
   endtask

   task automatic test_timeout();
      int         en_cnt, cyc;
      bit         rsp_seen;
      logic [1:0] rsp_v;
      logic       rsp_e;
      logic [3:0] psel_at;
      logic [31:0] rd_at;
      bus.req_valid   = 2'b01;
      bus.req_write   = 2'b00;
      bus.req_addr[0] = 32'h2000_0000;
      bus.PREADY      = 1'b0;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL to_accept got %b want 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      en_cnt = 0; cyc = 0; rsp_seen = 0;
      rsp_v = 2'b00; rsp_e = 1'b0; psel_at = 4'b0; rd_at = 32'h0;
      while (!rsp_seen && cyc < 100) begin
         if (bus.PENABLE) en_cnt++;
         if (bus.rsp_valid !== 2'b00) begin
            rsp_seen = 1;
            rsp_v    = bus.rsp_valid;
            rsp_e    = bus.rsp_err;
            rd_at    = bus.rsp_rdata;
            psel_at  = bus.PSEL;
         end else begin
            step();
         end
         cyc++;
      end
`ifdef APB_TIMEOUT_EN
      total++; if (rsp_seen !== 1'b1) begin bad++; $display("FAIL to_no_abort got none want rsp within 100 cycles"); end
      total++; if (en_cnt !== 16) begin bad++; $display("FAIL to_access_cycles got %0d want 16", en_cnt); end
      total++; if (rsp_v !== 2'b01 || rsp_e !== 1'b1 || rd_at !== 32'h0 || psel_at !== 4'b0)
         begin bad++; $display("FAIL to_rsp got v=%b err=%b rd=%h psel=%b want 01/1/0/0000", rsp_v, rsp_e, rd_at, psel_at); end
      step();
`else
      total++; if (rsp_seen !== 1'b0) begin bad++; $display("FAIL to_unexpected_rsp got v=%b want none", rsp_v); end
      total++; if (bus.PENABLE !== 1'b1 || bus.PSEL !== 4'b0100)
         begin bad++; $display("FAIL to_still_access got en=%b psel=%b want 1/0100", bus.PENABLE, bus.PSEL); end
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'hA5A5_5A5A;
      step();
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h0;
      total++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hA5A5_5A5A)
         begin bad++; $display("FAIL to_late_rsp got v=%b err=%b rd=%h want 01/0/a5a55a5a", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      step();
`endif
   endtask

   task automatic test_reset_access();
      bus.req_valid   = 2'b01;
      bus.req_write   = 2'b00;
      bus.req_addr[0] = 32'h0000_0010;
      bus.PREADY      = 1'b0;
      #1;
      step();
      bus.req_valid = 2'b00;
      step();
      total++; if (bus.PENABLE !== 1'b1) begin bad++; $display("FAIL ra_in_access got en=%b want 1", bus.PENABLE); end
      PRESET     = 1'b1;
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'hFFFF_0000;
      step();
      total++; if (bus.PSEL !== 4'b0 || bus.PENABLE !== 1'b0 || bus.req_ready !== 2'b0 || bus.PADDR !== 32'h0)
         begin bad++; $display("FAIL ra_apb got psel=%b en=%b rdy=%b addr=%h want 0", bus.PSEL, bus.PENABLE, bus.req_ready, bus.PADDR); end
      total++; if (bus.rsp_valid !== 2'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0)
         begin bad++; $display("FAIL ra_rsp got v=%b err=%b rd=%h want 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      PRESET     = 1'b0;
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h0;
      step();
      total++; if (bus.rsp_valid !== 2'b0) begin bad++; $display("FAIL ra_no_rsp got %b want 00", bus.rsp_valid); end
      bus.req_valid   = 2'b11;
      bus.req_addr[0] = 32'h0000_0020;
      bus.req_addr[1] = 32'h1000_0020;
      #1;
      total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL ra_prio got %b want 01", bus.req_ready); end
      step();
      bus.req_valid = 2'b00;
      bus.PREADY    = 1'b1;
      step();
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESET        = 1'b1;
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.PRDATA    = '0;
      bus.PREADY    = 1'b0;
      test_reset();
      test_single_write();
      test_read_wait();
      test_back_to_back();
      test_contention();
      test_decode_err();
      test_timeout();
      test_reset_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 SHALL have one clock, CLK; reset is synchronous and active-high, port PRESET.
REQ-002 CLK  input  1  sole clock; all state updates on posedge.
REQ-003 PRESET  input  1  synchronous active-high reset.
REQ-004 req_valid  input  2  per-requester transfer request; held with fields stable until accepted.
REQ-005 req_write / req_addr / req_wdata  input  2 / 2x32 / 2x32  per-requester direction, address, write data.
REQ-006 req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-007 rsp_valid  output  2  one-cycle completion pulse to the owning requester.
REQ-008 rsp_rdata / rsp_err  output  32 / 1  shared read data and error flag, valid only with rsp_valid.
REQ-009 PSEL  output  4  one-hot APB slave select.
REQ-010 PENABLE, PWRITE  output  1 each;  PADDR, PWDATA  output  32 each;  PRDATA  input  32;  PREADY  input  1.

Function
REQ-011 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-012 IDLE with any req_valid: grant one requester, assert its req_ready combinationally that cycle, capture its fields; next state SETUP.
REQ-013 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, requester 0 has priority.
REQ-014 Decode SHALL use PADDR[31:28]: values 0-3 select PSEL bit 0-3; any other value is a decode error.
REQ-015 Decode error: request accepted; no SETUP/ACCESS; PSEL stays 0; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; FSM stays IDLE.
REQ-016 SETUP (one cycle): PSEL one-hot, PENABLE=0, PADDR/PWRITE/PWDATA driven from captured fields; next state ACCESS.
REQ-017 ACCESS: PENABLE=1, all APB outputs held stable; remain while PREADY=0.
REQ-018 ACCESS with PREADY=1: capture PRDATA (reads only, else 0); next cycle rsp_valid to owner, rsp_err=0; FSM returns to IDLE.
REQ-019 The response cycle SHALL be an IDLE cycle that may accept a new request (accept-to-accept minimum 3 cycles with zero wait states).
REQ-020 PWDATA SHALL be 0 during read transfers; PADDR/PWRITE/PWDATA SHALL be 0 in IDLE.
REQ-021 req_ready SHALL never be asserted outside IDLE nor to more than one requester.
REQ-022 A requester dropping req_valid before acceptance SHALL NOT be granted.

Reset
REQ-023 PRESET SHALL force IDLE, round-robin pointer to favour requester 0, and all outputs to 0 (PSEL=0, PENABLE=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0).
REQ-024 Reset mid-transfer SHALL abandon the transfer with no rsp_valid issued.

Configuration
REQ-025 With APB_TIMEOUT_EN defined: an ACCESS wait counter aborts after TIMEOUT_CYCLES (16) consecutive PREADY=0 cycles; PSEL/PENABLE drop to 0, FSM goes IDLE, next cycle rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-026 Without APB_TIMEOUT_EN: no counter is instantiated and ACCESS waits indefinitely.

Structure
REQ-027 Package apb_ctrl_pkg SHALL hold the FSM state enum, the decode field position [31:28], NUM_SLV=4 and TIMEOUT_CYCLES=16.
REQ-028 Round-robin grant logic SHALL be a sub-module named apb_rr_arb (2 requests in, one-hot grant out, pointer update on accept).

Verification
REQ-029 Single write: req0 addr 0x1000_0040, wdata 0xDEAD_BEEF, PREADY=1 -> SETUP with PSEL=4'b0010, ACCESS next cycle, rsp_valid[0] 3 cycles after accept, rsp_err=0.
REQ-030 Read with 2 wait states: req1 addr 0x3000_0000, PRDATA=0x1234_5678 at PREADY -> PENABLE held 3 cycles, PSEL=4'b1000, rsp_rdata=0x1234_5678.
REQ-031 Contention: both requesters valid continuously after reset -> grants alternate 0,1,0,1; no double req_ready.
REQ-032 Decode error: req0 addr 0x7000_0000 -> PSEL never asserted, rsp_valid[0]=1, rsp_err=1 on the cycle after accept.
REQ-033 Timeout (APB_TIMEOUT_EN): PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1; without the macro, no response after 100 cycles.
REQ-034 Reset in ACCESS: PRESET=1 for 1 cycle -> all outputs 0, no rsp_valid; next request starts with requester 0 priority.
